// File: rtl/thor2022_btb_update_queue.sv
// BTB update queue: buffers resolved branches from execute and drains them
// into the BTB write port in arrival order. A branch whose ip is already
// pending is merged into that entry in place rather than queued again.
module thor2022_btb_update_queue #(
    parameter  int DEPTH = 4,
    parameter  int AWID  = 64,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            br_valid,
    input  logic [AWID-1:0] br_ip,
    input  logic [AWID-1:0] br_tgt,
    input  logic            br_taken,
    output logic            br_ready,
    input  logic            btb_busy,
    output logic            btb_wr,
    output logic [AWID-1:0] btb_wip,
    output logic [AWID-1:0] btb_wtgt,
    output logic            btb_takb,
    output logic [CW-1:0]   count,
    output logic [15:0]     merge_cnt
);

    logic [AWID-1:0] ip_q  [DEPTH];
    logic [AWID-1:0] tgt_q [DEPTH];
    logic [DEPTH-1:0] tak_q;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] hit_idx;
    logic          hit;
    logic          pop;
    logic          push;
    logic          merge;
    logic          head_merge;
    logic          not_full;
    logic          not_empty;

    assign not_empty  = (count != '0);
    assign not_full   = (count < CW'(DEPTH));
    assign pop        = not_empty && !btb_busy;
    assign merge      = br_valid && hit;
    assign push       = br_valid && !hit && not_full;
    assign br_ready   = hit || not_full;
    assign head_merge = merge && (hit_idx == head);

    // Search occupied entries for br_ip; the head is skipped while it pops,
    // so a branch colliding with the outgoing write is queued fresh instead.
    always_comb begin
        logic [PW-1:0] off;
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - head;
            if (({1'b0, off} < count) && !(pop && (off == '0)) && (ip_q[i] == br_ip)) begin
                hit     = 1'b1;
                hit_idx = PW'(i);
            end
        end
    end

    // Head entry drives the write port; a merge into a stalled head is
    // forwarded so the port always shows the newest target/direction.
    always_comb begin
        btb_wr   = pop;
        btb_wip  = '0;
        btb_wtgt = '0;
        btb_takb = 1'b0;
        if (not_empty) begin
            btb_wip  = ip_q[head];
            btb_wtgt = head_merge ? br_tgt   : tgt_q[head];
            btb_takb = head_merge ? br_taken : tak_q[head];
        end
    end

    // Pointers, occupancy and merge statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            merge_cnt <= '0;
        end else begin
            if (pop)
                head <= head + 1'b1;
            if (push)
                tail <= tail + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (merge && (merge_cnt != 16'hFFFF))
                merge_cnt <= merge_cnt + 1'b1;
        end
    end

    // Entry payloads; contents are don't-care until occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            ip_q[tail]  <= br_ip;
            tgt_q[tail] <= br_tgt;
            tak_q[tail] <= br_taken;
        end else if (merge) begin
            tgt_q[hit_idx] <= br_tgt;
            tak_q[hit_idx] <= br_taken;
        end
    end

endmodule

// File: tb/tb_thor2022_btb_update_queue.sv
// Bench for the BTB update queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_thor2022_btb_update_queue;

    localparam int DEPTH = 4;
    localparam int AWID  = 64;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            br_valid;
    logic [AWID-1:0] br_ip;
    logic [AWID-1:0] br_tgt;
    logic            br_taken;
    logic            br_ready;
    logic            btb_busy;
    logic            btb_wr;
    logic [AWID-1:0] btb_wip;
    logic [AWID-1:0] btb_wtgt;
    logic            btb_takb;
    logic [CW-1:0]   count;
    logic [15:0]     merge_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [AWID-1:0] ip;
        logic [AWID-1:0] tgt;
        logic            tak;
    } ent_t;

    ent_t q[$];
    ent_t wlog[$];
    ent_t dlog[$];
    int   m_merges;
    logic m_match;
    int   m_idx;
    logic exp_wr, exp_rdy, exp_tak;
    logic [AWID-1:0] exp_wip, exp_wtgt;
    int   exp_cnt;

    thor2022_btb_update_queue #(.DEPTH(DEPTH), .AWID(AWID)) dut (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_ip(br_ip), .br_tgt(br_tgt),
        .br_taken(br_taken), .br_ready(br_ready), .btb_busy(btb_busy), .btb_wr(btb_wr),
        .btb_wip(btb_wip), .btb_wtgt(btb_wtgt), .btb_takb(btb_takb), .count(count),
        .merge_cnt(merge_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected outputs for the current inputs, from the queue model.
    task automatic model_eval();
        exp_wr  = (q.size() != 0) && !btb_busy;
        m_match = 1'b0;
        m_idx   = -1;
        for (int i = (exp_wr ? 1 : 0); i < q.size(); i++)
            if (q[i].ip == br_ip) begin
                m_match = 1'b1;
                m_idx   = i;
            end
        exp_rdy  = m_match || (q.size() < DEPTH);
        exp_cnt  = q.size();
        exp_wip  = '0;
        exp_wtgt = '0;
        exp_tak  = 1'b0;
        if (q.size() != 0) begin
            exp_wip = q[0].ip;
            if (br_valid && m_match && m_idx == 0) begin
                exp_wtgt = br_tgt;
                exp_tak  = br_taken;
            end else begin
                exp_wtgt = q[0].tgt;
                exp_tak  = q[0].tak;
            end
        end
    endtask

    // Drive inputs shortly after a rising edge and settle.
    task automatic set_in(input logic v, input logic [AWID-1:0] ip, input logic [AWID-1:0] tg,
                          input logic tk, input logic bz);
        br_valid = v;
        br_ip    = ip;
        br_tgt   = tg;
        br_taken = tk;
        btb_busy = bz;
        #3;
        model_eval();
    endtask

    // Record the DUT write, advance the model and the clock.
    task automatic commit();
        logic psh;
        if (btb_wr) dlog.push_back('{btb_wip, btb_wtgt, btb_takb});
        psh = br_valid && !m_match && (q.size() < DEPTH);
        if (br_valid && m_match) begin
            q[m_idx].tgt = br_tgt;
            q[m_idx].tak = br_taken;
            if (m_merges < 65535) m_merges++;
        end
        if (exp_wr) begin
            wlog.push_back(q[0]);
            void'(q.pop_front());
        end
        if (psh) q.push_back('{br_ip, br_tgt, br_taken});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        br_valid = 1'b0;
        btb_busy = 1'b0;
        rst      = 1'b0;
        #2;
        rst      = 1'b1;
        q.delete();
        wlog.delete();
        dlog.delete();
        m_merges = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        br_valid = 1'b0; br_ip = '0; br_tgt = '0; br_taken = 1'b0; btb_busy = 1'b0;
        rst = 1'b0;
        #3;
        tests++;
        if (btb_wr !== 1'b0 || br_ready !== 1'b1 || count !== '0 || merge_cnt !== '0) begin
            fails++;
            $display("FAIL reset_state: wr=%b rdy=%b count=%0d merge=%0d, need wr=0 rdy=1 count=0 merge=0",
                     btb_wr, br_ready, count, merge_cnt);
        end
        @(posedge clk);
        #1;
        do_reset();
    endtask

    task automatic test_single_push();
        do_reset();
        set_in(1'b1, 64'h100, 64'h200, 1'b1, 1'b0);
        tests++;
        if (btb_wr !== 1'b0 || btb_wip !== '0) begin
            fails++;
            $display("FAIL single_no_bypass: wr=%b wip=%h, need wr=0 wip=0", btb_wr, btb_wip);
        end
        commit();
        set_in(1'b0, '0, '0, 1'b0, 1'b0);
        tests++;
        if (btb_wr !== 1'b1 || btb_wip !== 64'h100 || btb_wtgt !== 64'h200 || btb_takb !== 1'b1) begin
            fails++;
            $display("FAIL single_write: wr=%b wip=%h wtgt=%h takb=%b, need 1/100/200/1",
                     btb_wr, btb_wip, btb_wtgt, btb_takb);
        end
        commit();
        set_in(1'b0, '0, '0, 1'b0, 1'b0);
        tests++;
        if (count !== '0 || btb_wr !== 1'b0) begin
            fails++;
            $display("FAIL single_drained: count=%0d wr=%b, need 0/0", count, btb_wr);
        end
        commit();
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 64'(16 * (k + 1)), 64'(256 + k), 1'b1, 1'b1);
            tests++;
            if (br_ready !== 1'b1) begin
                fails++;
                $display("FAIL bp_fill_ready: push %0d rdy=%b, need 1", k, br_ready);
            end
            commit();
        end
        set_in(1'b1, 64'h50, 64'h500, 1'b1, 1'b1);
        tests++;
        if (count !== 3'd4 || br_ready !== 1'b0 || btb_wr !== 1'b0) begin
            fails++;
            $display("FAIL bp_full: count=%0d rdy=%b wr=%b, need 4/0/0", count, br_ready, btb_wr);
        end
        commit();
        set_in(1'b1, 64'h20, 64'h77, 1'b0, 1'b1);
        tests++;
        if (br_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_merge_ready: rdy=%b, need 1", br_ready);
        end
        commit();
        set_in(1'b0, '0, '0, 1'b0, 1'b1);
        tests++;
        if (merge_cnt !== 16'd1 || count !== 3'd4) begin
            fails++;
            $display("FAIL bp_merge_count: merge=%0d count=%0d, need 1/4", merge_cnt, count);
        end
        commit();
        for (int c = 0; c < 8; c++) begin
            set_in(1'b0, '0, '0, 1'b0, 1'b0);
            commit();
        end
        tests++;
        if (dlog.size() != 4) begin
            fails++;
            $display("FAIL bp_drain_size: writes=%0d, need 4", dlog.size());
        end else if (dlog[0].ip !== 64'h10 || dlog[1].ip !== 64'h20 || dlog[2].ip !== 64'h30 ||
                     dlog[3].ip !== 64'h40 || dlog[1].tgt !== 64'h77 || dlog[1].tak !== 1'b0) begin
            fails++;
            $display("FAIL bp_drain_order: ips=%h,%h,%h,%h tgt1=%h tak1=%b, need 10,20,30,40 77 0",
                     dlog[0].ip, dlog[1].ip, dlog[2].ip, dlog[3].ip, dlog[1].tgt, dlog[1].tak);
        end
    endtask

    task automatic test_merge();
        int n20;
        do_reset();
        set_in(1'b1, 64'h10, 64'h11, 1'b1, 1'b1); commit();
        set_in(1'b1, 64'h20, 64'h21, 1'b1, 1'b1); commit();
        set_in(1'b1, 64'h20, 64'h80, 1'b0, 1'b1); commit();
        for (int c = 0; c < 6; c++) begin
            set_in(1'b0, '0, '0, 1'b0, 1'b0);
            commit();
        end
        n20 = 0;
        foreach (dlog[i]) if (dlog[i].ip == 64'h20) n20++;
        tests++;
        if (dlog.size() != 2 || n20 != 1) begin
            fails++;
            $display("FAIL merge_single_write: writes=%0d of_0x20=%0d, need 2/1", dlog.size(), n20);
        end else if (dlog[1].ip !== 64'h20 || dlog[1].tgt !== 64'h80 || dlog[1].tak !== 1'b0) begin
            fails++;
            $display("FAIL merge_payload: ip=%h tgt=%h tak=%b, need 20/80/0", dlog[1].ip, dlog[1].tgt, dlog[1].tak);
        end
    endtask

    task automatic test_head_collision();
        do_reset();
        set_in(1'b1, 64'h10, 64'h55, 1'b1, 1'b1); commit();
        set_in(1'b1, 64'h10, 64'h99, 1'b1, 1'b0);
        tests++;
        if (btb_wr !== 1'b1 || btb_wip !== 64'h10 || btb_wtgt !== 64'h55 || br_ready !== 1'b1) begin
            fails++;
            $display("FAIL collide_old: wr=%b wip=%h wtgt=%h rdy=%b, need 1/10/55/1", btb_wr, btb_wip, btb_wtgt, br_ready);
        end
        commit();
        set_in(1'b0, '0, '0, 1'b0, 1'b0);
        tests++;
        if (btb_wr !== 1'b1 || btb_wip !== 64'h10 || btb_wtgt !== 64'h99 || merge_cnt !== 16'd0) begin
            fails++;
            $display("FAIL collide_new: wr=%b wip=%h wtgt=%h merge=%0d, need 1/10/99/0", btb_wr, btb_wip, btb_wtgt, merge_cnt);
        end
        commit();
    endtask

    task automatic test_head_merge_busy();
        do_reset();
        set_in(1'b1, 64'h40, 64'h41, 1'b1, 1'b1); commit();
        set_in(1'b1, 64'h40, 64'h42, 1'b0, 1'b1);
        tests++;
        if (btb_wip !== 64'h40 || btb_wtgt !== 64'h42 || btb_takb !== 1'b0 || btb_wr !== 1'b0) begin
            fails++;
            $display("FAIL head_merge_fwd: wip=%h wtgt=%h takb=%b wr=%b, need 40/42/0/0", btb_wip, btb_wtgt, btb_takb, btb_wr);
        end
        commit();
    endtask

    task automatic test_wraparound();
        int   sent, cyc, bad;
        logic hold, v, acc;
        do_reset();
        sent = 0; hold = 1'b0; cyc = 0; bad = 0;
        while (dlog.size() < 10 && cyc < 300) begin
            v = (sent < 10) && (hold || ($urandom_range(0, 2) != 0));
            set_in(v, 64'(4096 + sent * 8), 64'(8192 + sent), sent[0], 1'($urandom_range(0, 1)));
            tests++;
            if (count > 3'd4 || count !== CW'(exp_cnt)) begin
                fails++;
                $display("FAIL wrap_count: count=%0d, need %0d (max 4)", count, exp_cnt);
            end
            acc = v && br_ready;
            commit();
            if (acc) sent++;
            hold = v && !acc;
            cyc++;
        end
        tests++;
        if (dlog.size() != 10) begin
            fails++;
            $display("FAIL wrap_total: writes=%0d, need 10 (cycles=%0d)", dlog.size(), cyc);
        end else begin
            foreach (dlog[i]) if (dlog[i].ip !== 64'(4096 + i * 8)) bad++;
            if (bad != 0) begin
                fails++;
                $display("FAIL wrap_order: %0d writes out of order or wrong ip", bad);
            end
        end
    endtask

    task automatic test_random();
        int bad;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            set_in(1'($urandom_range(0, 1)), 64'($urandom_range(1, 8) * 16), 64'($urandom),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 60));
            tests++;
            if (btb_wr !== exp_wr || br_ready !== exp_rdy || count !== CW'(exp_cnt) ||
                btb_wip !== exp_wip || btb_wtgt !== exp_wtgt || btb_takb !== exp_tak) begin
                fails++;
                $display("FAIL rand_cycle %0d: wr=%b rdy=%b cnt=%0d wip=%h wtgt=%h takb=%b, need %b %b %0d %h %h %b",
                         c, btb_wr, br_ready, count, btb_wip, btb_wtgt, btb_takb,
                         exp_wr, exp_rdy, exp_cnt, exp_wip, exp_wtgt, exp_tak);
            end
            commit();
        end
        tests++;
        if (merge_cnt !== 16'(m_merges)) begin
            fails++;
            $display("FAIL rand_merge_cnt: merge=%0d, need %0d", merge_cnt, m_merges);
        end
        bad = 0;
        if (dlog.size() != wlog.size()) bad = 1;
        else foreach (dlog[i])
            if (dlog[i].ip !== wlog[i].ip || dlog[i].tgt !== wlog[i].tgt || dlog[i].tak !== wlog[i].tak) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL rand_write_log: %0d writes vs %0d expected, %0d differ", dlog.size(), wlog.size(), bad);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_in(1'b1, 64'h10, 64'h1, 1'b1, 1'b1); commit();
        set_in(1'b1, 64'h20, 64'h2, 1'b1, 1'b1); commit();
        set_in(1'b1, 64'h10, 64'h3, 1'b0, 1'b1); commit();
        set_in(1'b1, 64'h30, 64'h4, 1'b1, 1'b1); commit();
        set_in(1'b0, '0, '0, 1'b0, 1'b0);
        tests++;
        if (count !== 3'd3 || merge_cnt !== 16'd1 || btb_wr !== 1'b1) begin
            fails++;
            $display("FAIL mid_pre: count=%0d merge=%0d wr=%b, need 3/1/1", count, merge_cnt, btb_wr);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (btb_wr !== 1'b0 || count !== '0 || br_ready !== 1'b1 || merge_cnt !== '0) begin
            fails++;
            $display("FAIL mid_async_clear: wr=%b count=%0d rdy=%b merge=%0d, need 0/0/1/0", btb_wr, count, br_ready, merge_cnt);
        end
        q.delete(); wlog.delete(); dlog.delete(); m_merges = 0;
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 6; c++) begin
            set_in(1'b0, '0, '0, 1'b0, 1'b0);
            tests++;
            if (btb_wr !== 1'b0 || count !== '0) begin
                fails++;
                $display("FAIL mid_post_idle %0d: wr=%b count=%0d, need 0/0", c, btb_wr, count);
            end
            commit();
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_backpressure();
        test_merge();
        test_head_collision();
        test_head_merge_busy();
        test_wraparound();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/thor2022_btb_update_queue.md
THOR2022_BTB_UPDATE_QUEUE -- requirements
Module: Thor2022_btb_update_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, meaning the number of queue entries (power of two, 2..16).
REQ-002 SHALL provide parameter AWID, default 64, meaning the width of the Address type.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port br_valid, input, 1, execute stage presents a resolved branch.
REQ-006 SHALL have port br_ip, input, AWID, the resolved branch instruction address.
REQ-007 SHALL have port br_tgt, input, AWID, the resolved branch target address.
REQ-008 SHALL have port br_taken, input, 1, the resolved branch direction.
REQ-009 SHALL have port br_ready, output, 1, the queue accepts the presented branch this cycle.
REQ-010 SHALL have port btb_busy, input, 1, the BTB write port is unavailable this cycle.
REQ-011 SHALL have port btb_wr, output, 1, the BTB write strobe.
REQ-012 SHALL have port btb_wip, output, AWID, the BTB write instruction address.
REQ-013 SHALL have port btb_wtgt, output, AWID, the BTB write target.
REQ-014 SHALL have port btb_takb, output, 1, the BTB write valid/taken bit.
REQ-015 SHALL have port count, output, clog2(DEPTH)+1, the number of occupied entries.
REQ-016 SHALL have port merge_cnt, output, 16, a saturating count of coalesced updates.

Function
REQ-017 SHALL implement a circular FIFO with head/tail pointers of clog2(DEPTH) bits that wrap modulo DEPTH; each entry holds ip, tgt and taken.
REQ-018 SHALL drive btb_wr = (count != 0) && !btb_busy; btb_wip, btb_wtgt and btb_takb SHALL come combinationally from the head entry, and SHALL be 0 when count = 0.
REQ-019 SHALL pop the head (advance head, decrement count) on every cycle in which btb_wr = 1.
REQ-020 SHALL compare br_ip against every occupied entry, excluding the head when it pops in the same cycle; a hit is a "match".
REQ-021 SHALL, on br_valid && match, overwrite the matching entry's tgt and taken in place, leave count and tail unchanged, and increment merge_cnt, saturating at 16'hFFFF.
REQ-022 SHALL, on br_valid && !match && count < DEPTH, write the entry at tail, advance tail and increment count.
REQ-023 SHALL drive br_ready = match || (count < DEPTH); a full queue with no match SHALL deassert br_ready and drop nothing. The producer holds br_valid and its data.
REQ-024 SHALL keep count unchanged on a simultaneous push and pop; count SHALL never exceed DEPTH or underflow.
REQ-025 SHALL have no same-cycle bypass: a push into an empty queue appears on btb_wr no earlier than the next cycle.
REQ-026 SHALL, when a branch matches the head while the head pops, enqueue it as a new entry; the popped write keeps the old data.
REQ-027 SHALL, under btb_busy = 1, hold the head stable and continue accepting or merging pushes. A merge into the head SHALL update btb_wtgt and btb_takb in the same cycle.
REQ-028 SHALL maintain the invariant that no two occupied entries hold the same ip.
REQ-029 SHALL drain the queue in strict arrival order of first insertion; a merge does not reorder.

Reset
REQ-030 SHALL, while rst = 0, immediately and asynchronously clear head, tail, count and merge_cnt to 0, forcing btb_wr = 0 and br_ready = 1.
REQ-031 SHALL leave entry payloads unspecified after reset; no occupied-entry match is possible with count = 0.
REQ-032 SHALL discard in-flight queue contents when reset is asserted mid-operation, with no BTB write from pre-reset entries after release.

Verification
REQ-033 SHALL verify single push: empty queue, push ip=0x100, tgt=0x200, taken=1 at cycle 0 -> cycle 1 btb_wr=1, btb_wip=0x100, btb_wtgt=0x200, btb_takb=1; cycle 2 count=0.
REQ-034 SHALL verify full backpressure: btb_busy=1, push ip 0x10, 0x20, 0x30, 0x40 -> count=4; a fifth push of 0x50 -> br_ready=0. Push of 0x20 -> br_ready=1, merge_cnt=1, count=4.
REQ-035 SHALL verify merge: pending ip=0x20 with taken=1, then push ip=0x20, tgt=0x80, taken=0 -> the drained entry for 0x20 carries tgt=0x80, takb=0, and only one write for 0x20 occurs.
REQ-036 SHALL verify head-pop collision: head ip=0x10 popping while ip=0x10 with tgt=0x99 is pushed -> writes 0x10/old target then 0x10/0x99 on consecutive cycles.
REQ-037 SHALL verify wrap-around: 10 pushes and pops interleaved with random btb_busy -> writes emerge in order with no loss or duplication, and count never exceeds 4.
REQ-038 SHALL verify reset mid-operation: count=3, assert rst=0 between clock edges -> btb_wr=0 and count=0 immediately; after release, no writes occur without new pushes.
